// File: rtl/rotate_solve.sv
// rotate_solve: finds the smallest rotation k that maps a onto r, one step per clock.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif
module rotate_solve #(
  parameter int n    = `DEFAULT_WIDTH,
  parameter bit left = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [n-1:0]         a,
  input  logic [n-1:0]         r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(n)-1:0] amount,
  output logic                 found
);
  localparam int w = $clog2(n);
  localparam logic [1:0] idle = 2'd0, search = 2'd1, done = 2'd2;
  logic [1:0]   state;
  logic [n-1:0] cand, target, rot1;
  logic [w:0]   k;
  assign rot1      = left ? {cand[n-2:0], cand[n-1]} : {cand[0], cand[n-1:1]};
  assign in_ready  = state == idle;
  assign out_valid = state == done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= idle;
      cand   <= '0;
      target <= '0;
      k      <= '0;
      amount <= '0;
      found  <= 1'b0;
    end else begin
      case (state)
        idle: if (in_valid) begin
          cand   <= a;
          target <= r;
          k      <= '0;
          state  <= search;
        end
        search: if (cand == target) begin
          amount <= k[w-1:0];
          found  <= 1'b1;
          state  <= done;
        end else if (k == (w+1)'(n-1)) begin
          amount <= '0;
          found  <= 1'b0;
          state  <= done;
        end else begin
          cand <= rot1;
          k    <= k + 1'b1;
        end
        done: if (out_ready) state <= idle;
        default: state <= idle;
      endcase
    end
endmodule

// File: tb/tb_rotate_solve.sv
// tb_rotate_solve: directed and random checks of both rotation directions against a search model.
module tb_rotate_solve;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sel = 1'b1;
  logic [7:0] a = '0, r = '0;
  logic ir_l, ir_r, ov_l, ov_r, fd_l, fd_r;
  logic [2:0] am_l, am_r;
  logic ir, ov, fd;
  logic [2:0] am;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rotate_solve #(.n(8), .left(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir_l), .a(a), .r(r),
    .out_valid(ov_l), .out_ready(out_ready & sel), .amount(am_l), .found(fd_l));
  rotate_solve #(.n(8), .left(1'b0)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir_r), .a(a), .r(r),
    .out_valid(ov_r), .out_ready(out_ready & ~sel), .amount(am_r), .found(fd_r));

  assign ir = sel ? ir_l : ir_r;
  assign ov = sel ? ov_l : ov_r;
  assign fd = sel ? fd_l : fd_r;
  assign am = sel ? am_l : am_r;

  function automatic logic [7:0] rot(input logic [7:0] x, input int b, input bit lf);
    logic [15:0] d = {x, x};
    int s = b % 8;
    return lf ? d[15-s -: 8] : d[s +: 8];
  endfunction

  task automatic run_req(input bit lf, input logic [7:0] aa, input logic [7:0] rr, input string nm);
    int ek = 0, lat = 0;
    bit ef = 1'b0;
    for (int i = 7; i >= 0; i--) if (rot(aa, i, lf) == rr) begin ef = 1'b1; ek = i; end
    sel = lf;
    @(posedge clk); #1;
    in_valid = 1'b1; a = aa; r = rr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!ov && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== (ef ? ek + 1 : 8)) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, ef ? ek + 1 : 8); end
    checks++; if (fd !== ef) begin errors++; $display("FAIL %s found got %b want %b", nm, fd, ef); end
    checks++; if (am !== 3'(ek)) begin errors++; $display("FAIL %s amount got %0d want %0d", nm, am, ek); end
    if (fd === 1'b1) begin
      checks++; if (rot(aa, int'(am), lf) !== rr) begin errors++; $display("FAIL %s contract rot(a,%0d)=%h want %h", nm, am, rot(aa, int'(am), lf), rr); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({ir, ov} !== 2'b10) begin errors++; $display("FAIL %s post-handshake in_ready,out_valid got %b want 10", nm, {ir, ov}); end
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({ir_l, ov_l, fd_l, am_l, ir_r, ov_r, fd_r, am_r} !== 12'b100000100000) begin
      errors++; $display("FAIL reset outputs got %b want 100000100000", {ir_l, ov_l, fd_l, am_l, ir_r, ov_r, fd_r, am_r});
    end
    @(posedge clk); #3; rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_req(1'b1, 8'b10000111, 8'b00001111, "left_hit1");
    run_req(1'b0, 8'b10000111, 8'b11110000, "right_hit3");
    run_req(1'b1, 8'b10101010, 8'b01010101, "periodic");
    run_req(1'b1, 8'hFF, 8'hFF, "ones");
    run_req(1'b0, 8'h00, 8'h00, "zeros");
    run_req(1'b1, 8'b10000111, 8'b10000011, "miss_l");
    run_req(1'b0, 8'b10000111, 8'b10000011, "miss_r");
    run_req(1'b1, 8'b00000001, 8'b10000000, "left_hit7");
    run_req(1'b0, 8'b00000001, 8'b10000000, "right_hit1");
  endtask

  task automatic test_backpressure;
    int lat = 0;
    sel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'b10000111; r = 8'b00001111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!ov && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a = 8'($urandom);
      @(posedge clk); #1;
      checks++; if ({ov, ir, fd, am} !== 6'b101001) begin
        errors++; $display("FAIL backpressure cycle %0d ov,ir,fd,am got %b want 101001", i, {ov, ir, fd, am});
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({ir, ov} !== 2'b10) begin errors++; $display("FAIL backpressure release ir,ov got %b want 10", {ir, ov}); end
    @(posedge clk); #1;
    checks++; if ({ir, ov} !== 2'b10) begin errors++; $display("FAIL backpressure single handshake ir,ov got %b want 10", {ir, ov}); end
  endtask

  task automatic test_reset_mid_search;
    sel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'b10000111; r = 8'b10000011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL mid_search busy in_ready got %b want 0", ir); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ir, ov, fd, am} !== 6'b100000) begin errors++; $display("FAIL async_reset ir,ov,fd,am got %b want 100000", {ir, ov, fd, am}); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_req(1'b1, 8'b10000111, 8'b00111100, "after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] x = 8'($urandom);
      int b = int'($urandom_range(0, 7));
      run_req(1'b1, x, rot(x, b, 1'b1), "rand_left");
      run_req(1'b0, x, rot(x, b, 1'b0), "rand_right");
    end
    for (int i = 0; i < 50; i++) begin
      bit lf = 1'($urandom);
      run_req(lf, 8'($urandom), 8'($urandom), "rand_any");
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_search;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
